// File: rtl/sram_port_arb.sv
// rtl/sram_port_arb.sv - two-requester round-robin arbiter onto one shared SRAM port
// Optional busy-timeout abort is compiled in with MARB_TIMEOUT_EN.
module sram_port_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_cs,
  input  logic        s0_we,
  input  logic [31:0] s0_addr,
  input  logic [3:0]  s0_byte,
  input  logic [31:0] s0_di,
  output logic [31:0] s0_do,
  output logic        s0_busy,
  output logic        s0_err,
  input  logic        s1_cs,
  input  logic        s1_we,
  input  logic [31:0] s1_addr,
  input  logic [3:0]  s1_byte,
  input  logic [31:0] s1_di,
  output logic [31:0] s1_do,
  output logic        s1_busy,
  output logic        s1_err,
  output logic        m_cs,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byte,
  output logic [31:0] m_di,
  input  logic [31:0] m_do,
  input  logic        m_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        rr, rr_nxt;
  logic        own, own_cs, own_we, other_cs, abort;
  logic [31:0] own_addr, own_di;
  logic [3:0]  own_byte;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("sram_port_arb: TIMEOUT must be within 1..255");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

`ifdef MARB_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  logic [7:0] cnt;

  assign abort = (state != IDLE) && (cnt == TMO);

  // Counts only stalled cycles of an ongoing grant; any completion or owner change restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= 8'd0;
    else if (state_nxt == state && state != IDLE && m_cs && m_busy)
      cnt <= cnt + 8'd1;
    else
      cnt <= 8'd0;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    own      = (state == OWN1);
    own_cs   = own ? s1_cs   : s0_cs;
    own_we   = own ? s1_we   : s0_we;
    own_addr = own ? s1_addr : s0_addr;
    own_byte = own ? s1_byte : s0_byte;
    own_di   = own ? s1_di   : s0_di;
    other_cs = own ? s0_cs   : s1_cs;
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    m_cs      = 1'b0;
    m_we      = 1'b0;
    m_addr    = 32'd0;
    m_byte    = 4'd0;
    m_di      = 32'd0;
    s0_busy   = s0_cs;
    s1_busy   = s1_cs;
    s0_do     = 32'd0;
    s1_do     = 32'd0;
    s0_err    = 1'b0;
    s1_err    = 1'b0;
    case (state)
      IDLE: begin
        if (s0_cs || s1_cs)
          state_nxt = (s0_cs && (!rr || !s1_cs)) ? OWN0 : OWN1;
      end
      OWN0, OWN1: begin
        m_cs   = own_cs && !abort;
        m_we   = own_we;
        m_addr = own_addr;
        m_byte = own_byte;
        m_di   = own_di;
        if (own) begin
          s1_busy = m_busy && !abort;
          s1_do   = m_do;
          s1_err  = abort;
        end else begin
          s0_busy = m_busy && !abort;
          s0_do   = m_do;
          s0_err  = abort;
        end
        // Completion hands priority to the other side so a pending request switches with no bubble.
        if (abort) begin
          rr_nxt    = !own;
          state_nxt = IDLE;
        end else if (!own_cs) begin
          state_nxt = IDLE;
        end else if (!m_busy) begin
          rr_nxt    = !own;
          state_nxt = other_cs ? (own ? OWN0 : OWN1) : state;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_port_arb.sv
// tb/tb_sram_port_arb.sv - scoreboard bench for sram_port_arb
// Define MARB_TIMEOUT_EN for both files to include the timeout scenario.
module tb_sram_port_arb;

  logic        clk, rst;
  logic        s0_cs, s0_we, s0_busy, s0_err;
  logic [31:0] s0_addr, s0_di, s0_do;
  logic [3:0]  s0_byte;
  logic        s1_cs, s1_we, s1_busy, s1_err;
  logic [31:0] s1_addr, s1_di, s1_do;
  logic [3:0]  s1_byte;
  logic        m_cs, m_we, m_busy;
  logic [31:0] m_addr, m_di, m_do;
  logic [3:0]  m_byte;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          order[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem [0:255];
  int          busy_cfg = 0;
  int          busy_cnt = 0;
  logic        busy_stuck = 1'b0;

  sram_port_arb #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .s0_cs(s0_cs), .s0_we(s0_we), .s0_addr(s0_addr), .s0_byte(s0_byte), .s0_di(s0_di),
    .s0_do(s0_do), .s0_busy(s0_busy), .s0_err(s0_err),
    .s1_cs(s1_cs), .s1_we(s1_we), .s1_addr(s1_addr), .s1_byte(s1_byte), .s1_di(s1_di),
    .s1_do(s1_do), .s1_busy(s1_busy), .s1_err(s1_err),
    .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_byte(m_byte), .m_di(m_di),
    .m_do(m_do), .m_busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int k);
    return 32'hA000_0000 | (32'(k) << 8) | 32'(k);
  endfunction

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = pat(k);
    mem[64] = 32'hDEADBEEF;
    mem[65] = 32'hCAFEF00D;
  end

  // Memory-side responder: each access stalls busy_cfg cycles unless stuck.
  assign m_do   = mem[m_addr[9:2]];
  assign m_busy = m_cs && (busy_stuck || busy_cnt != 0);
  always @(posedge clk) begin
    if (!m_cs || busy_cnt == 0) busy_cnt <= busy_cfg;
    else busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic score(input int side);
    exp_t e;
    if ((side == 0 && q0.size() == 0) || (side == 1 && q1.size() == 0)) begin
      check($sformatf("sb%0d_unexpected", side), 32'd1, 32'd0);
      return;
    end
    e = (side == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("sb%0d_m_cs", side), 32'(m_cs), 32'd1);
    check($sformatf("sb%0d_m_we", side), 32'(m_we), 32'(e.we));
    check($sformatf("sb%0d_m_addr", side), m_addr, e.addr);
    check($sformatf("sb%0d_m_byte", side), 32'(m_byte), 32'(e.be));
    if (e.we) check($sformatf("sb%0d_m_di", side), m_di, e.wd);
    else check($sformatf("sb%0d_do", side), (side == 0) ? s0_do : s1_do, e.rd);
    order.push_back(side);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (s0_cs && !s0_busy && !s0_err) score(0);
      if (s1_cs && !s1_busy && !s1_err) score(1);
    end
  end

  task automatic req(input int side, input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] rd, input bit last, output int stalls);
    exp_t e;
    bit   done;
    e = '{we, addr, be, wd, rd};
    if (side == 0) begin
      s0_cs = 1'b1; s0_we = we; s0_addr = addr; s0_byte = be; s0_di = wd; q0.push_back(e);
    end else begin
      s1_cs = 1'b1; s1_we = we; s1_addr = addr; s1_byte = be; s1_di = wd; q1.push_back(e);
    end
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if ((side == 0) ? !s0_busy : !s1_busy) done = 1'b1;
      else stalls++;
    end
    if (!done) check($sformatf("req%0d_timeout", side), 32'd0, 32'd1);
    @(posedge clk); #1;
    if (last || !done) begin
      if (side == 0) begin s0_cs = 1'b0; s0_we = 1'b0; end
      else begin s1_cs = 1'b0; s1_we = 1'b0; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int st0, st1, nb;
    bit hit;
    rst = 1'b1;
    s0_cs = 0; s0_we = 0; s0_addr = 0; s0_byte = 0; s0_di = 0;
    s1_cs = 0; s1_we = 0; s1_addr = 0; s1_byte = 0; s1_di = 0;
    #1;
    check("rst_m_cs", 32'(m_cs), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_s0_err", 32'(s0_err), 32'd0);
    check("rst_s1_err", 32'(s1_err), 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);
    check("rst_rr", 32'(dut.rr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single s0 read: one arbitration stall then completion.
    req(0, 1'b0, 32'h100, 4'hF, 32'd0, 32'hDEADBEEF, 1'b1, st0);
    check("t1_stalls", 32'(st0), 32'd1);
    check("t1_rr", 32'(dut.rr), 32'd1);

    // Simultaneous requests with rr=0.
    do_reset();
    order.delete();
    fork
      req(0, 1'b0, 32'h100, 4'hF, 32'd0, 32'hDEADBEEF, 1'b1, st0);
      req(1, 1'b0, 32'h104, 4'hF, 32'd0, 32'hCAFEF00D, 1'b1, st1);
    join
    check("t2_s0_stalls", 32'(st0), 32'd1);
    check("t2_s1_stalls", 32'(st1), 32'd2);
    check("t2_first", 32'(order[0]), 32'd0);
    check("t2_second", 32'(order[1]), 32'd1);
    check("t2_rr", 32'(dut.rr), 32'd0);

    // s1 write with 3 busy cycles while s0 waits.
    repeat (2) @(posedge clk); #1;
    busy_cfg = 3;
    @(posedge clk); #1;
    fork
      req(1, 1'b1, 32'h200, 4'b0011, 32'h12345678, 32'd0, 1'b1, st1);
      begin
        @(posedge clk); #1;
        req(0, 1'b0, 32'h100, 4'hF, 32'd0, 32'hDEADBEEF, 1'b1, st0);
      end
      repeat (6) begin
        @(negedge clk);
        if (dut.state == 2'd2 && m_busy) begin
          check("t3_m_addr", m_addr, 32'h200);
          check("t3_m_di", m_di, 32'h12345678);
          check("t3_m_byte", 32'(m_byte), 32'h3);
          check("t3_m_we", 32'(m_we), 32'd1);
          check("t3_s0_blk", 32'(s0_busy), 32'(s0_cs));
          check("t3_s0_do", s0_do, 32'd0);
        end
      end
    join
    check("t3_s1_stalls", 32'(st1), 32'd4);
    busy_cfg = 0;

    // Back-to-back traffic from both sides.
    repeat (3) @(posedge clk); #1;
    order.delete();
    fork
      for (int i = 0; i < 20; i++) begin
        int s;
        req(0, 1'b0, 32'((i + 1) * 4), 4'hF, 32'd0, pat(i + 1), i == 19, s);
      end
      for (int j = 0; j < 20; j++) begin
        int s;
        req(1, 1'b0, 32'((j + 33) * 4), 4'hF, 32'd0, pat(j + 33), j == 19, s);
      end
    join
    check("t4_count", 32'(order.size()), 32'd40);
    check("t4_first_s1", 32'(order[0]), 32'd1);
    for (int i = 1; i < order.size(); i++)
      check($sformatf("t4_alt%0d", i), 32'(order[i]), 32'(order[i - 1] ^ 1));

    // Reset during a stalled s1 access.
    repeat (3) @(posedge clk); #1;
    busy_cfg = 10;
    @(posedge clk); #1;
    s1_cs = 1'b1; s1_we = 1'b1; s1_addr = 32'h300; s1_byte = 4'hF; s1_di = 32'h55AA55AA;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (dut.state == 2'd2 && m_busy) hit = 1'b1;
    end
    check("t5_own1", 32'(hit), 32'd1);
    check("t5_pre_mcs", 32'(m_cs), 32'd1);
    check("t5_pre_rr", 32'(dut.rr), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_mcs_async", 32'(m_cs), 32'd0);
    check("t5_maddr_async", m_addr, 32'd0);
    s1_cs = 1'b0; s1_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    busy_cfg = 0;
    check("t5_state", 32'(dut.state), 32'd0);
    check("t5_rr", 32'(dut.rr), 32'd0);

`ifdef MARB_TIMEOUT_EN
    // Stuck m_busy aborts s0 after TIMEOUT busy cycles, then pending s1 is granted.
    repeat (2) @(posedge clk); #1;
    busy_stuck = 1'b1;
    s0_cs = 1'b1; s0_we = 1'b0; s0_addr = 32'h100; s0_byte = 4'hF;
    s1_cs = 1'b1; s1_we = 1'b0; s1_addr = 32'h104; s1_byte = 4'hF;
    q1.push_back('{1'b0, 32'h104, 4'hF, 32'd0, 32'hCAFEF00D});
    order.delete();
    nb  = 0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (s0_err) hit = 1'b1;
      else if (m_cs && m_busy) nb++;
    end
    check("t6_err_seen", 32'(hit), 32'd1);
    check("t6_busy_cycles", 32'(nb), 32'd4);
    check("t6_err_busy", 32'(s0_busy), 32'd0);
    check("t6_err_mcs", 32'(m_cs), 32'd0);
    @(posedge clk); #1;
    s0_cs = 1'b0;
    busy_stuck = 1'b0;
    @(negedge clk);
    check("t6_err_pulse", 32'(s0_err), 32'd0);
    check("t6_idle", 32'(dut.state), 32'd0);
    check("t6_rr", 32'(dut.rr), 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (!s1_busy) hit = 1'b1;
      else @(negedge clk);
    end
    check("t6_s1_done", 32'(hit), 32'd1);
    @(posedge clk); #1;
    s1_cs = 1'b0;
    check("t6_s1_granted", 32'(order.size()), 32'd1);
`endif

    repeat (2) @(posedge clk); #1;
    check("end_q0_empty", 32'(q0.size()), 32'd0);
    check("end_q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of consecutive m_busy cycles before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have ports s0_cs, s1_cs  input  1  requester chip select, held until completion.
REQ-005 SHALL have ports s0_we, s1_we  input  1  write enable.
REQ-006 SHALL have ports s0_addr, s1_addr  input  32  byte address.
REQ-007 SHALL have ports s0_byte, s1_byte  input  4  byte strobes.
REQ-008 SHALL have ports s0_di, s1_di  input  32  write data.
REQ-009 SHALL have ports s0_do, s1_do  output  32  read data.
REQ-010 SHALL have ports s0_busy, s1_busy  output  1  stall; the access completes in the cycle where cs=1 and busy=0.
REQ-011 SHALL have ports s0_err, s1_err  output  1  one-cycle abort pulse.
REQ-012 SHALL have ports m_cs, m_we (output, 1), m_addr (output, 32), m_byte (output, 4), m_di (output, 32), m_do (input, 32) and m_busy (input, 1), forming a shared single memory port with the same protocol.

Function
REQ-013 SHALL implement an FSM with states IDLE, OWN0 and OWN1.
REQ-014 In IDLE, SHALL drive m_cs=0, and SHALL drive sN_busy=1 for every requester whose sN_cs=1.
REQ-015 From IDLE with any cs=1, SHALL move to OWN of the requester selected by the round-robin pointer rr.
- rr=0 favours s0; rr=1 favours s1.
- Arbitration costs exactly one cycle.
REQ-016 In OWNn, SHALL route sn_cs/we/addr/byte/di combinationally to m_*.
- sn_busy = m_busy; sn_do = m_do; the other requester sees busy=cs and do=0.
REQ-017 On the completion cycle (m_cs=1, m_busy=0) in OWNn, SHALL load rr with the other requester's index.
- Next state = OWN(other) if other cs=1; else OWNn if sn_cs=1; else IDLE.
- A switch between owners takes zero bubble cycles.
REQ-018 If sn_cs drops in OWNn while m_busy=0, SHALL return to IDLE. Dropping cs while busy=1 is illegal and unchecked.
REQ-019 SHALL hold the grant for the entire duration of m_busy=1; ownership SHALL never change mid-access.
REQ-020 With both requesters continuously active, grants SHALL alternate strictly, so the worst-case wait is one foreign access.
REQ-021 When not in OWN state, SHALL drive all m_* outputs to 0.

Reset
REQ-022 While rst=1, SHALL force state=IDLE and rr=0, and SHALL clear all m_* outputs and sN_err immediately, without waiting for clk.
REQ-023 Reset asserted mid-access SHALL abandon the access; the memory side tolerates a dropped m_cs.
REQ-024 After rst deassertion, the first arbitration SHALL occur on the first clk edge at which any cs=1.

Configuration
REQ-025 With MARB_TIMEOUT_EN defined, SHALL run an 8-bit counter that increments for each OWN cycle with m_busy=1 and clears on completion or on a state change.
- When the counter reaches TIMEOUT: pulse sn_err=1 and sn_busy=0 for one cycle.
- In that cycle, force m_cs=0, set rr to the other requester, and go to IDLE.
REQ-026 Without MARB_TIMEOUT_EN, SHALL not implement the counter and SHALL tie s0_err and s1_err to 0.

Verification
REQ-027 Bench SHALL cover: after reset, s0 read at 0x100 with m_busy=0 -> one IDLE stall cycle, then completion with s0_do=m_do=0xDEADBEEF.
REQ-028 Bench SHALL cover: s0 and s1 both cs=1 from the same cycle with rr=0 -> s0 served first, then s1 served on the next cycle with no bubble; rr ends at 0.
REQ-029 Bench SHALL cover: s1 write 0x12345678, byte=4'b0011, m_busy=1 for 3 cycles -> s1_busy=1 for 4 cycles, m_* stable, and s0 blocked throughout.
REQ-030 Bench SHALL cover: 20 back-to-back requests from each side -> strictly alternating grants.
REQ-031 Bench SHALL cover: rst pulsed while OWN1 and m_busy=1 -> m_cs=0 in the same cycle; after release, state=IDLE and rr=0.
REQ-032 Bench SHALL cover, with MARB_TIMEOUT_EN and TIMEOUT=4: m_busy stuck high -> s0_err pulses after 4 busy cycles, then pending s1 is granted.
